// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline-control definitions: controller states, the opcodes that read rt, and helpers.
// Imported by every file of the stall_ctrl slice.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // Instructions that actually read rt as a source; loads and I-type ALU ops write it instead.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_SB) ||
               (op == OP_BEQ)   || (op == OP_BNE);
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Hazard-detection bundle between the pipeline datapath (master) and the stall controller (slave).
interface stall_ctrl_if;
    logic [5:0] ifid_op;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       idex_mem_read;
    logic [4:0] idex_rt;
    logic       branch_taken;
    logic       muldiv_start;
    logic       muldiv_is_div;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       md_busy;
    logic       md_done;

    modport master (
        output ifid_op, ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               branch_taken, muldiv_start, muldiv_is_div,
        input  pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done
    );

    modport slave (
        input  ifid_op, ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               branch_taken, muldiv_start, muldiv_is_div,
        output pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done
    );
endinterface

// File: rtl/stall_ctrl_muldiv_timer.sv
// Down-counter that tracks multiply/divide occupancy; flags the last busy cycle (count == 1).
module muldiv_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_is_one = (r_count == W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, taken-branch flushes and optional mult/div occupancy.
// Mult/div tracking is built only when STALL_CTRL_MULDIV_EN is defined.
module stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    stall_ctrl_if.slave  bus
);

    logic w_load_use;
    logic w_run_pc_write;
    logic w_run_ifid_write;
    logic w_run_ifid_flush;
    logic w_run_idex_flush;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_md_busy;
    logic w_md_done;

    assign w_load_use = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                        ((bus.idex_rt == bus.ifid_rs) ||
                         (uses_rt(bus.ifid_op) && (bus.idex_rt == bus.ifid_rt)));

    // Normal-flow decision; a taken branch flushes the younger instruction so it wins over load-use.
    always_comb begin
        w_run_pc_write   = 1'b1;
        w_run_ifid_write = 1'b1;
        w_run_ifid_flush = 1'b0;
        w_run_idex_flush = 1'b0;
        if (bus.branch_taken) begin
            w_run_ifid_flush = 1'b1;
        end else if (w_load_use) begin
            w_run_pc_write   = 1'b0;
            w_run_ifid_write = 1'b0;
            w_run_idex_flush = 1'b1;
        end
    end

`ifdef STALL_CTRL_MULDIV_EN
    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    state_e           r_state;
    state_e           w_next;
    logic             w_load;
    logic             w_dec;
    logic             w_is_one;
    logic [CNT_W-1:0] w_load_val;

    assign w_load_val = bus.muldiv_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_pc_write   = w_run_pc_write;
        w_ifid_write = w_run_ifid_write;
        w_ifid_flush = w_run_ifid_flush;
        w_idex_flush = w_run_idex_flush;
        w_md_busy    = 1'b0;
        w_md_done    = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.muldiv_start) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_ifid_flush = 1'b0;
                    w_idex_flush = 1'b0;
                    w_md_busy    = 1'b1;
                    w_load       = 1'b1;
                    w_next       = MD_WAIT;
                end
            end
            MD_WAIT: begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_ifid_flush = 1'b0;
                w_idex_flush = 1'b0;
                w_md_busy    = 1'b1;
                w_dec        = 1'b1;
                if (w_is_one) begin
                    w_next = MD_DONE;
                end
            end
            MD_DONE: begin
                w_md_done = 1'b1;
                w_next    = RUN;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    muldiv_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_value  (w_load_val),
        .i_dec    (w_dec),
        .o_is_one (w_is_one)
    );
`else
    logic w_unused_md;

    assign w_unused_md  = ^{clk, bus.muldiv_start, bus.muldiv_is_div};
    assign w_pc_write   = w_run_pc_write;
    assign w_ifid_write = w_run_ifid_write;
    assign w_ifid_flush = w_run_ifid_flush;
    assign w_idex_flush = w_run_idex_flush;
    assign w_md_busy    = 1'b0;
    assign w_md_done    = 1'b0;
`endif

    // Held reset freezes fetch and bubbles both pipeline registers.
    assign bus.pc_write   = rst ? 1'b0 : w_pc_write;
    assign bus.ifid_write = rst ? 1'b0 : w_ifid_write;
    assign bus.ifid_flush = rst ? 1'b1 : w_ifid_flush;
    assign bus.idex_flush = rst ? 1'b1 : w_idex_flush;
    assign bus.md_busy    = rst ? 1'b0 : w_md_busy;
    assign bus.md_done    = rst ? 1'b0 : w_md_done;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl; output vector is {pc_write, ifid_write, ifid_flush, idex_flush, md_busy, md_done}.
// Mult/div scenarios run when STALL_CTRL_MULDIV_EN is defined, otherwise the disabled-unit scenario runs.
module tb_stall_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    localparam logic [5:0] V_RESET = 6'b001100;
    localparam logic [5:0] V_IDLE  = 6'b110000;
    localparam logic [5:0] V_LDUSE = 6'b000100;
    localparam logic [5:0] V_BRAN  = 6'b111000;
    localparam logic [5:0] V_BUSY  = 6'b000010;
    localparam logic [5:0] V_DONE  = 6'b110001;
    localparam logic [5:0] V_DONEB = 6'b111001;

    typedef struct {
        logic       mr;
        logic [4:0] xrt;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[10];

    stall_ctrl_if bus();

    stall_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.md_busy, bus.md_done};
    endfunction

    task automatic set_hazard(input logic mr, input logic [4:0] xrt, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt);
        bus.idex_mem_read = mr;
        bus.idex_rt       = xrt;
        bus.ifid_op       = op;
        bus.ifid_rs       = rs;
        bus.ifid_rt       = rt;
    endtask

    task automatic clear_inputs();
        set_hazard(1'b0, 5'd0, 6'd0, 5'd0, 5'd0);
        bus.branch_taken  = 1'b0;
        bus.muldiv_start  = 1'b0;
        bus.muldiv_is_div = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        total++;
        if (outs() !== V_RESET) begin
            $display("[TB] FAIL reset_idle got=%b want=%b", outs(), V_RESET);
            bad++;
        end
        @(negedge clk);
        bus.branch_taken = 1'b1;
        bus.muldiv_start = 1'b1;
        set_hazard(1'b1, 5'd8, 6'd0, 5'd8, 5'd0);
        #2;
        total++;
        if (outs() !== V_RESET) begin
            $display("[TB] FAIL reset_overrides got=%b want=%b", outs(), V_RESET);
            bad++;
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #2;
        total++;
        if (outs() !== V_IDLE) begin
            $display("[TB] FAIL reset_release got=%b want=%b", outs(), V_IDLE);
            bad++;
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_hazard(1'b1, 5'd8, 6'b000000, 5'd8, 5'd10);
        #2;
        total++;
        if (outs() !== V_LDUSE) begin
            $display("[TB] FAIL load_use_stall got=%b want=%b", outs(), V_LDUSE);
            bad++;
        end
        @(negedge clk);
        set_hazard(1'b0, 5'd0, 6'b000000, 5'd8, 5'd10);
        #2;
        total++;
        if (outs() !== V_IDLE) begin
            $display("[TB] FAIL load_use_release got=%b want=%b", outs(), V_IDLE);
            bad++;
        end
    endtask

    task automatic test_hazard_cases();
        vecs[0] = '{1'b1, 5'd0, 6'b000000, 5'd0, 5'd0, V_IDLE,  "rt_zero"};
        vecs[1] = '{1'b1, 5'd9, 6'b101011, 5'd3, 5'd9, V_LDUSE, "sw_rt"};
        vecs[2] = '{1'b1, 5'd9, 6'b001000, 5'd3, 5'd9, V_IDLE,  "addi_rt"};
        vecs[3] = '{1'b1, 5'd9, 6'b001000, 5'd9, 5'd4, V_LDUSE, "addi_rs"};
        vecs[4] = '{1'b0, 5'd9, 6'b000000, 5'd9, 5'd9, V_IDLE,  "no_load"};
        vecs[5] = '{1'b1, 5'd9, 6'b000100, 5'd3, 5'd9, V_LDUSE, "beq_rt"};
        vecs[6] = '{1'b1, 5'd9, 6'b000101, 5'd3, 5'd9, V_LDUSE, "bne_rt"};
        vecs[7] = '{1'b1, 5'd9, 6'b101000, 5'd3, 5'd9, V_LDUSE, "sb_rt"};
        vecs[8] = '{1'b1, 5'd9, 6'b100011, 5'd3, 5'd9, V_IDLE,  "lw_rt"};
        vecs[9] = '{1'b1, 5'd9, 6'b000000, 5'd3, 5'd8, V_IDLE,  "no_match"};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_hazard(vecs[i].mr, vecs[i].xrt, vecs[i].op, vecs[i].rs, vecs[i].rt);
            #2;
            total++;
            if (outs() !== vecs[i].exp) begin
                $display("[TB] FAIL hazard_%s got=%b want=%b", vecs[i].name, outs(), vecs[i].exp);
                bad++;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_hazard(1'b1, 5'd8, 6'b000000, 5'd8, 5'd0);
        bus.branch_taken = 1'b1;
        #2;
        total++;
        if (outs() !== V_BRAN) begin
            $display("[TB] FAIL branch_beats_load_use got=%b want=%b", outs(), V_BRAN);
            bad++;
        end
        @(negedge clk);
        set_hazard(1'b0, 5'd0, 6'd0, 5'd0, 5'd0);
        #2;
        total++;
        if (outs() !== V_BRAN) begin
            $display("[TB] FAIL branch_alone got=%b want=%b", outs(), V_BRAN);
            bad++;
        end
        @(negedge clk);
        clear_inputs();
        #2;
        total++;
        if (outs() !== V_IDLE) begin
            $display("[TB] FAIL branch_release got=%b want=%b", outs(), V_IDLE);
            bad++;
        end
    endtask

`ifdef STALL_CTRL_MULDIV_EN
    task automatic test_muldiv(input logic is_div, input int n, input string name);
        logic [5:0] exp;
        @(negedge clk);
        bus.muldiv_start  = 1'b1;
        bus.muldiv_is_div = is_div;
        set_hazard(1'b1, 5'd8, 6'b000000, 5'd8, 5'd0);
        #2;
        total++;
        if (outs() !== V_BUSY) begin
            $display("[TB] FAIL %s_issue got=%b want=%b", name, outs(), V_BUSY);
            bad++;
        end
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            if (k == 2) bus.muldiv_start = 1'b1;
            if (k == 3) bus.muldiv_start = 1'b0;
            exp = (k < n) ? V_BUSY : ((k == n) ? V_DONE : V_IDLE);
            #2;
            total++;
            if (outs() !== exp) begin
                $display("[TB] FAIL %s_cycle%0d got=%b want=%b", name, k, outs(), exp);
                bad++;
            end
        end
    endtask

    task automatic test_muldiv_branch();
        logic [5:0] exp;
        @(negedge clk);
        bus.muldiv_start  = 1'b1;
        bus.muldiv_is_div = 1'b0;
        bus.branch_taken  = 1'b1;
        #2;
        total++;
        if (outs() !== V_BUSY) begin
            $display("[TB] FAIL mdbr_issue got=%b want=%b", outs(), V_BUSY);
            bad++;
        end
        for (int k = 1; k <= MUL_N + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.muldiv_start = 1'b0;
            if (k == MUL_N + 1) bus.branch_taken = 1'b0;
            exp = (k < MUL_N) ? V_BUSY : ((k == MUL_N) ? V_DONEB : V_IDLE);
            #2;
            total++;
            if (outs() !== exp) begin
                $display("[TB] FAIL mdbr_cycle%0d got=%b want=%b", k, outs(), exp);
                bad++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.muldiv_start  = 1'b1;
        bus.muldiv_is_div = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            #2;
            total++;
            if (outs() !== V_BUSY) begin
                $display("[TB] FAIL abort_busy%0d got=%b want=%b", k, outs(), V_BUSY);
                bad++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        total++;
        if (outs() !== V_RESET) begin
            $display("[TB] FAIL abort_reset got=%b want=%b", outs(), V_RESET);
            bad++;
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (outs() !== V_IDLE) begin
            $display("[TB] FAIL abort_async_run got=%b want=%b", outs(), V_IDLE);
            bad++;
        end
        for (int k = 1; k <= DIV_N + 4; k++) begin
            @(negedge clk);
            #2;
            total++;
            if (outs() !== V_IDLE) begin
                $display("[TB] FAIL abort_after%0d got=%b want=%b", k, outs(), V_IDLE);
                bad++;
            end
        end
    endtask
`else
    task automatic test_muldiv_disabled();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.muldiv_start  = (k == 0) || (k == 4);
            bus.muldiv_is_div = (k < 4);
            #2;
            total++;
            if (outs() !== V_IDLE) begin
                $display("[TB] FAIL md_disabled%0d got=%b want=%b", k, outs(), V_IDLE);
                bad++;
            end
        end
        clear_inputs();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_hazard_cases();
        test_branch();
`ifdef STALL_CTRL_MULDIV_EN
        test_muldiv(1'b0, MUL_N, "mul");
        test_muldiv(1'b1, DIV_N, "div");
        test_muldiv_branch();
        test_reset_abort();
`else
        test_muldiv_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, 4, multiply occupancy in cycles; SHALL be at least 2.
REQ-002 Parameter DIV_CYCLES, 32, divide occupancy in cycles; SHALL be at least 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ifid_op  in  6  opcode of the IF/ID instruction.
REQ-006 ifid_rs / ifid_rt  in  5 each  source registers of the IF/ID instruction.
REQ-007 idex_mem_read  in  1  ID/EX instruction is a load (lw/lb/lbu).
REQ-008 idex_rt  in  5  load destination in ID/EX.
REQ-009 branch_taken  in  1  taken branch/jump resolved this cycle; upstream holds it until it is honoured.
REQ-010 muldiv_start  in  1  EX-stage mult/div issue, 1-cycle pulse; muldiv_is_div  in  1  selects DIV_CYCLES.
REQ-011 pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-012 ifid_flush, idex_flush  out  1 each  bubble inserts.
REQ-013 md_busy  out  1  unit occupied; md_done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be RUN, MD_WAIT and MD_DONE; outputs SHALL be combinational from state and inputs.
REQ-015 uses_rt SHALL be 1 for ifid_op 000000, 101011, 101000, 000100 and 000101.
REQ-016 Load-use SHALL be: idex_mem_read && idex_rt!=0 && (idex_rt==ifid_rs || (uses_rt && idex_rt==ifid_rt)).
REQ-017 RUN, idle: pc_write=1, ifid_write=1, flushes=0, md_busy=0, md_done=0.
REQ-018 RUN with load-use only: pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle; the bubble clears the condition with no extra state.
REQ-019 RUN with branch_taken: ifid_flush=1 and pc_write=1; branch_taken SHALL beat load-use in the same cycle, with no stall.
REQ-020 RUN with muldiv_start in cycle T: it SHALL beat branch_taken and load-use.
  - outputs: pc_write=0, ifid_write=0, idex_flush=0, md_busy=1.
  - counter SHALL load N-1 (N=DIV_CYCLES if muldiv_is_div, else MUL_CYCLES); next state MD_WAIT.
REQ-021 MD_WAIT: stall outputs as in REQ-020; counter decrements each cycle; state SHALL go to MD_DONE when the counter equals 1.
  - muldiv_start and branch_taken SHALL be ignored.
REQ-022 MD_DONE (cycle T+N): md_done=1, md_busy=0, stalls released; next state RUN.
  - branch_taken and load-use SHALL be evaluated as in RUN.
REQ-023 md_busy SHALL be high for exactly N cycles (T..T+N-1); md_done SHALL be high only at T+N.

Reset
REQ-024 On rst: state=RUN, counter=0 immediately (asynchronously).
  - While rst is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, md_busy=0, md_done=0.
REQ-025 rst during MD_WAIT SHALL abort the operation with no md_done pulse.

Configuration
REQ-026 Macro STALL_CTRL_MULDIV_EN defined: REQ-020..REQ-023 SHALL apply.
REQ-027 Macro undefined: muldiv_start and muldiv_is_div SHALL be ignored; md_busy=md_done=0; no counter or MD states SHALL be built.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum and the opcode constants used in REQ-015.
REQ-029 The counter SHALL be sub-module muldiv_timer (load, value, decrement, count==1 flag), instantiated only under the macro.

Verification
REQ-030 lw $t0 in ID/EX (idex_rt=8), add $t1,$t0,$t2 in IF/ID -> one cycle with pc_write=0, idex_flush=1, then normal flow.
REQ-031 idex_rt=0 load with ifid_rs=0 -> no stall; sw with idex_rt==ifid_rt -> stall; addi with idex_rt==ifid_rt only -> no stall.
REQ-032 muldiv_start with muldiv_is_div=1 at cycle 10 -> md_busy high cycles 10..41, md_done at 42; with muldiv_is_div=0 -> md_done at 14.
REQ-033 muldiv_start and branch_taken at cycle T with branch_taken held -> stall for N cycles, ifid_flush=1 at T+N together with md_done.
REQ-034 rst pulsed at cycle 5 of a divide -> state RUN at once, no md_done, outputs per REQ-024.
REQ-035 Macro undefined build, muldiv_start pulsed -> no stall, md_busy=md_done=0.
